// File: rtl/mux_2a1_sel.sv
// Registered 2-to-1 operand selector: passes Dato or its two's-complement
// negation to the ALU operand bus, with registered zero and negation-overflow
// flags. One cycle of latency and no combinational path from inputs to outputs.
module mux_2a1_sel #(
    parameter int WIDTH = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             SEL,
    input  logic [WIDTH-1:0] Dato,
    output logic [WIDTH-1:0] Y,
    output logic             Z,
    output logic             OVF
);

    // The only value whose negation does not fit in WIDTH bits.
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] y_q;
    logic             z_d;
    logic             z_q;
    logic             ovf_d;
    logic             ovf_q;

    // Next result: pass-through or negation. Negating MOST_NEG wraps back to
    // itself naturally, so only the overflow flag needs special handling.
    always_comb begin
        y_d   = Dato;
        ovf_d = 1'b0;
        if (SEL) begin
            y_d   = ~Dato + ONE;
            ovf_d = (Dato == MOST_NEG);
        end
        z_d = (y_d == '0);
    end

    // Result register. Reset wins over EN. With EN low nothing is loaded,
    // so unknown SEL/Dato values cannot reach the outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            y_q   <= '0;
            z_q   <= 1'b1;
            ovf_q <= 1'b0;
        end else if (EN) begin
            y_q   <= y_d;
            z_q   <= z_d;
            ovf_q <= ovf_d;
        end
    end

    assign Y   = y_q;
    assign Z   = z_q;
    assign OVF = ovf_q;

endmodule

// File: tb/tb_mux_2a1_sel.sv
// Self-checking bench for mux_2a1_sel (WIDTH=6). Outputs are sampled 1 ns
// after the rising edge; inputs are driven at the same point so they are
// stable well before the next edge.
module tb_mux_2a1_sel;

    localparam int W = 6;

    logic         CLK;
    logic         RST;
    logic         EN;
    logic         SEL;
    logic [W-1:0] Dato;
    logic [W-1:0] Y;
    logic         Z;
    logic         OVF;

    bit clk_run;
    int vectors;
    int miscompares;

    mux_2a1_sel #(.WIDTH(W)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (EN),
        .SEL  (SEL),
        .Dato (Dato),
        .Y    (Y),
        .Z    (Z),
        .OVF  (OVF)
    );

    // Gated clock so reset can be checked with no clock running.
    initial CLK = 1'b0;
    always begin
        #5;
        if (clk_run) CLK = ~CLK;
    end

    // Reference: interpret Dato as a signed integer, negate with plain integer
    // arithmetic, flag results outside the signed W-bit range, then wrap.
    // Returned as {y, z, ovf}.
    function automatic logic [W+1:0] ref_result(input logic sel, input logic [W-1:0] d);
        int s;
        int r;
        logic [W-1:0] y;
        logic ovf;
        s   = (int'(d) >= (1 << (W-1))) ? int'(d) - (1 << W) : int'(d);
        r   = sel ? -s : s;
        ovf = (r > (1 << (W-1)) - 1);
        y   = W'((r + (1 << W)) % (1 << W));
        return {y, (y == '0), ovf};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [W+1:0] got;
        clk_run = 0;
        EN = 1'b0; SEL = 1'b0; Dato = '0;
        RST = 1'b1;
        #3;
        got = {Y, Z, OVF};
        vectors++;
        if (got !== {6'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_no_clk: got Y=%0d Z=%b OVF=%b, want Y=0 Z=1 OVF=0", Y, Z, OVF);
        end
        #2;
        RST = 1'b0;
        EN = 1'b1; SEL = 1'b0; Dato = 6'd9;
        #2;
        clk_run = 1;
        tick();
        got = {Y, Z, OVF};
        vectors++;
        if (got !== {6'd9, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_release: got Y=%0d Z=%b OVF=%b, want Y=9 Z=0 OVF=0", Y, Z, OVF);
        end
        $display("reset: Y=%0d Z=%b OVF=%b", Y, Z, OVF);
    endtask

    task automatic test_select_switch();
        logic [W+1:0] got;
        SEL = 1'b1; Dato = 6'd9;
        tick();
        got = {Y, Z, OVF};
        vectors++;
        if (got !== {6'd55, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL select_neg: got Y=%0d Z=%b OVF=%b, want Y=55 Z=0 OVF=0", Y, Z, OVF);
        end
        $display("select SEL=1 Dato=9: Y=%0d Z=%b OVF=%b", Y, Z, OVF);
        SEL = 1'b0;
        tick();
        got = {Y, Z, OVF};
        vectors++;
        if (got !== {6'd9, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL select_pass: got Y=%0d Z=%b OVF=%b, want Y=9 Z=0 OVF=0", Y, Z, OVF);
        end
        $display("select SEL=0 Dato=9: Y=%0d Z=%b OVF=%b", Y, Z, OVF);
    endtask

    task automatic test_boundary();
        logic [W-1:0] din  [4] = '{6'd32, 6'd0, 6'd63, 6'd31};
        logic [W+1:0] want [4] = '{{6'd32, 1'b0, 1'b1}, {6'd0, 1'b1, 1'b0},
                                   {6'd1, 1'b0, 1'b0}, {6'd33, 1'b0, 1'b0}};
        logic [W+1:0] got;
        EN = 1'b1; SEL = 1'b1;
        for (int i = 0; i < 4; i++) begin
            Dato = din[i];
            tick();
            got = {Y, Z, OVF};
            vectors++;
            if (got !== want[i]) begin
                miscompares++;
                $display("FAIL boundary Dato=%0d: got Y=%0d Z=%b OVF=%b, want Y=%0d Z=%b OVF=%b",
                         din[i], Y, Z, OVF, want[i][W+1:2], want[i][1], want[i][0]);
            end
            $display("boundary SEL=1 Dato=%0d: Y=%0d Z=%b OVF=%b", din[i], Y, Z, OVF);
        end
    endtask

    task automatic test_enable_hold();
        logic [W+1:0] got;
        EN = 1'b1; SEL = 1'b0; Dato = 6'd9;
        tick();
        EN = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                SEL  = 1'bx;
                Dato = 'x;
            end else begin
                SEL  = i[0];
                Dato = W'((i * 7) % 64);
            end
            tick();
            got = {Y, Z, OVF};
            vectors++;
            if (got !== {6'd9, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL enable_hold cycle %0d: got Y=%0d Z=%b OVF=%b, want Y=9 Z=0 OVF=0",
                         i, Y, Z, OVF);
            end
            $display("hold cycle %0d: Y=%0d Z=%b OVF=%b", i, Y, Z, OVF);
        end
    endtask

    task automatic test_reset_mid();
        logic [W+1:0] got;
        EN = 1'b1; SEL = 1'b1; Dato = 6'd5;
        #2;
        RST = 1'b1;
        #1;
        got = {Y, Z, OVF};
        vectors++;
        if (got !== {6'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_mid: got Y=%0d Z=%b OVF=%b, want Y=0 Z=1 OVF=0", Y, Z, OVF);
        end
        #2;
        RST = 1'b0;
        tick();
        got = {Y, Z, OVF};
        vectors++;
        if (got !== {6'd59, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_mid_release: got Y=%0d Z=%b OVF=%b, want Y=59 Z=0 OVF=0", Y, Z, OVF);
        end
        $display("reset mid-op then SEL=1 Dato=5: Y=%0d Z=%b OVF=%b", Y, Z, OVF);
    endtask

    task automatic test_throughput();
        logic [W+1:0] got;
        logic [W+1:0] want;
        EN = 1'b1;
        for (int i = 0; i < 200; i++) begin
            SEL  = 1'($urandom_range(0, 1));
            Dato = W'($urandom_range(0, 63));
            if (i % 50 == 0) Dato = 6'd32;
            want = ref_result(SEL, Dato);
            tick();
            got = {Y, Z, OVF};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL throughput %0d SEL=%b Dato=%0d: got Y=%0d Z=%b OVF=%b, want Y=%0d Z=%b OVF=%b",
                         i, SEL, Dato, Y, Z, OVF, want[W+1:2], want[1], want[0]);
            end
            $display("throughput %0d SEL=%b Dato=%0d: Y=%0d Z=%b OVF=%b", i, SEL, Dato, Y, Z, OVF);
        end
    endtask

    task automatic test_back_to_back();
        logic [W+1:0] got;
        logic [W+1:0] held;
        held = {Y, Z, OVF};
        for (int i = 0; i < 60; i++) begin
            EN   = 1'($urandom_range(0, 1));
            SEL  = 1'($urandom_range(0, 1));
            Dato = W'($urandom_range(0, 63));
            if (EN) held = ref_result(SEL, Dato);
            tick();
            got = {Y, Z, OVF};
            vectors++;
            if (got !== held) begin
                miscompares++;
                $display("FAIL back_to_back %0d EN=%b SEL=%b Dato=%0d: got Y=%0d Z=%b OVF=%b, want Y=%0d Z=%b OVF=%b",
                         i, EN, SEL, Dato, Y, Z, OVF, held[W+1:2], held[1], held[0]);
            end
            $display("b2b %0d EN=%b SEL=%b Dato=%0d: Y=%0d Z=%b OVF=%b", i, EN, SEL, Dato, Y, Z, OVF);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clk_run     = 0;
        RST = 1'b0; EN = 1'b0; SEL = 1'b0; Dato = '0;
        test_reset();
        test_select_switch();
        test_boundary();
        test_enable_hold();
        test_reset_mid();
        test_throughput();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
